// File: rtl/cpu_timing_pkg.sv
// Shared beat/phase encodings and the beat sequencing rule for beat_timing_gen.
package cpu_timing_pkg;

  localparam int BEATS_PER_PHASE_MAX = 3;

  typedef enum logic [1:0] {BEAT_W1, BEAT_W2, BEAT_W3} beat_e;
  typedef enum logic [$clog2(BEATS_PER_PHASE_MAX)-1:0] {PH_T1, PH_T2, PH_T3} phase_e;

  // W3 and any illegal encoding fall back to W1
  function automatic beat_e next_beat(beat_e cur, logic short_fb, logic long_fb);
    case (cur)
      BEAT_W1: next_beat = short_fb ? BEAT_W1 : BEAT_W2;
      BEAT_W2: next_beat = long_fb ? BEAT_W3 : BEAT_W1;
      default: next_beat = BEAT_W1;
    endcase
  endfunction

  function automatic logic [2:0] beat_levels(beat_e b);
    case (b)
      BEAT_W2: beat_levels = 3'b010;
      BEAT_W3: beat_levels = 3'b001;
      default: beat_levels = 3'b100;
    endcase
  endfunction

endpackage

// File: rtl/qd_sync_edge.sv
// Synchronizes the asynchronous qd button and emits a 1-clk pulse on its rising edge.
module qd_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/beat_timing_gen.sv
// Machine-cycle timing generator: t1/t2/t3 phase strobes and w1/w2/w3 beat levels.
// Define SINGLE_STEP_EN to add the dp port, which halts after every beat like stop.
module beat_timing_gen
  import cpu_timing_pkg::*;
#(
  parameter int PHASE_CYCLES = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic qd,
  input  logic short,
  input  logic long,
  input  logic stop,
`ifdef SINGLE_STEP_EN
  input  logic dp,
`endif
  output logic t1,
  output logic t2,
  output logic t3,
  output logic w1,
  output logic w2,
  output logic w3,
  output logic running
);

  localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PHASE_CYCLES - 1);

  beat_e          beat;
  beat_e          beat_nxt;
  phase_e         phase;
  logic [PW-1:0]  presc;
  logic           start;
  logic           halt_req;
  logic           phase_last;

  qd_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_qd_sync (
    .clk  (clk),
    .clr  (clr),
    .d    (qd),
    .pulse(start)
  );

`ifdef SINGLE_STEP_EN
  assign halt_req = stop | dp;
`else
  assign halt_req = stop;
`endif

  assign phase_last = (presc == PRESC_LAST);
  assign beat_nxt   = next_beat(beat, short, long);

  // A start pulse only counts while halted; the clk after running rises is a
  // dead cycle, after which T1 of the held beat begins.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      beat         <= BEAT_W1;
      phase        <= PH_T1;
      presc        <= '0;
      running      <= 1'b0;
      {t1, t2, t3} <= 3'b000;
      {w1, w2, w3} <= 3'b100;
    end else if (!running) begin
      presc        <= '0;
      phase        <= PH_T1;
      {t1, t2, t3} <= 3'b000;
      if (start) running <= 1'b1;
    end else if (!(t1 | t2 | t3)) begin
      presc        <= '0;
      phase        <= PH_T1;
      {t1, t2, t3} <= 3'b100;
    end else if (!phase_last) begin
      presc <= presc + PW'(1);
    end else begin
      presc <= '0;
      case (phase)
        PH_T1: begin
          phase        <= PH_T2;
          {t1, t2, t3} <= 3'b010;
        end
        PH_T2: begin
          phase        <= PH_T3;
          {t1, t2, t3} <= 3'b001;
        end
        PH_T3: begin
          // Beat boundary: feedback is sampled here and nowhere else
          beat         <= beat_nxt;
          {w1, w2, w3} <= beat_levels(beat_nxt);
          phase        <= PH_T1;
          if (halt_req) begin
            running      <= 1'b0;
            {t1, t2, t3} <= 3'b000;
          end else begin
            {t1, t2, t3} <= 3'b100;
          end
        end
        default: begin
          beat         <= BEAT_W1;
          {w1, w2, w3} <= 3'b100;
          phase        <= PH_T1;
          {t1, t2, t3} <= 3'b100;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beat_timing_gen.sv
// Scoreboard bench for beat_timing_gen: expected beats are queued at each boundary
// and popped when the DUT enters T1 (or halts).
module tb_beat_timing_gen;

  localparam int PHASE_CYCLES = 1;
  localparam int SYNC_STAGES  = 2;
  localparam int START_LAT    = SYNC_STAGES + 2;

  logic clk   = 1'b0;
  logic clr   = 1'b1;
  logic qd    = 1'b0;
  logic short = 1'b0;
  logic long  = 1'b0;
  logic stop  = 1'b0;
`ifdef SINGLE_STEP_EN
  logic dp    = 1'b0;
`endif
  logic t1, t2, t3, w1, w2, w3, running;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_cur;
  logic [2:0] got;

  beat_timing_gen #(.PHASE_CYCLES(PHASE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk    (clk),
    .clr    (clr),
    .qd     (qd),
    .short  (short),
    .long   (long),
    .stop   (stop),
`ifdef SINGLE_STEP_EN
    .dp     (dp),
`endif
    .t1     (t1),
    .t2     (t2),
    .t3     (t3),
    .w1     (w1),
    .w2     (w2),
    .w3     (w3),
    .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] phase_bits(int idx);
    case (idx)
      0:       return 3'b100;
      1:       return 3'b010;
      default: return 3'b001;
    endcase
  endfunction

  function automatic logic [2:0] next_w(logic [2:0] cur, logic s, logic l);
    if (cur == 3'b100) return s ? 3'b100 : 3'b010;
    if (cur == 3'b010) return l ? 3'b001 : 3'b100;
    return 3'b100;
  endfunction

  task automatic pop_expected();
    if (exp_q.size() != 0) got = exp_q.pop_front();
    else got = 3'bxxx;
  endtask

  task automatic wait_t1(output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    qd  = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (t1 === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
    qd = 1'b0;
  endtask

  task automatic test_reset();
    #1 clr = 1'b0;
    #2;
    checks++;
    if ({w1, w2, w3, t1, t2, t3, running} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_async got=%b exp=%b", {w1, w2, w3, t1, t2, t3, running}, 7'b1000000);
    end
    tick();
    tick();
    clr = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({w1, w2, w3, t1, t2, t3, running} !== 7'b1000000) begin
        errors++;
        $display("[TB] FAIL reset_hold cyc=%0d got=%b exp=%b", i, {w1, w2, w3, t1, t2, t3, running}, 7'b1000000);
      end
    end
  endtask

  task automatic test_short_hold();
    int cyc;
    bit ok;
    short = 1'b1; long = 1'b0; stop = 1'b0;
    exp_cur = 3'b100;
    exp_q.push_back(3'b100);
    wait_t1(cyc, ok);
    checks++;
    if (!ok || cyc != START_LAT) begin
      errors++;
      $display("[TB] FAIL start_latency got=%0d exp=%0d ok=%0b", cyc, START_LAT, ok);
    end
    for (int k = 0; k < 12; k++) begin
      if (k > 0) tick();
      checks++;
      if ({t1, t2, t3, running} !== {phase_bits(k % 3), 1'b1}) begin
        errors++;
        $display("[TB] FAIL short_phase k=%0d got=%b exp=%b", k, {t1, t2, t3, running}, {phase_bits(k % 3), 1'b1});
      end
      if (k % 3 == 0) begin
        pop_expected();
        checks++;
        if ({w1, w2, w3} !== got) begin
          errors++;
          $display("[TB] FAIL short_beat k=%0d got=%b exp=%b", k, {w1, w2, w3}, got);
        end
      end
      if (k % 3 == 2) begin
        exp_cur = next_w(exp_cur, short, long);
        exp_q.push_back(exp_cur);
      end
    end
  endtask

  task automatic test_long_sequence();
    logic [1:0] plan [8] = '{2'b01, 2'b11, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    int w1_starts[$];
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if ({t1, t2, t3, running} !== {phase_bits(k % 3), 1'b1}) begin
        errors++;
        $display("[TB] FAIL seq_phase k=%0d got=%b exp=%b", k, {t1, t2, t3, running}, {phase_bits(k % 3), 1'b1});
      end
      if (t1 === 1'b1 && w1 === 1'b1) w1_starts.push_back(k);
      if (k % 3 == 0) begin
        pop_expected();
        checks++;
        if ({w1, w2, w3} !== got) begin
          errors++;
          $display("[TB] FAIL seq_beat k=%0d got=%b exp=%b", k, {w1, w2, w3}, got);
        end
        short = 1'($urandom_range(0, 1));
        long  = 1'($urandom_range(0, 1));
        stop  = 1'($urandom_range(0, 1));
      end
      if (k % 3 == 2) begin
        {short, long} = plan[k / 3];
        stop = 1'b0;
        exp_cur = next_w(exp_cur, short, long);
        exp_q.push_back(exp_cur);
      end
    end
    checks++;
    if (w1_starts.size() != 3 || (w1_starts[1] - w1_starts[0]) != 9) begin
      errors++;
      $display("[TB] FAIL loop_period starts=%0d got=%0d exp=9", w1_starts.size(),
               (w1_starts.size() > 1) ? w1_starts[1] - w1_starts[0] : -1);
    end
  endtask

  task automatic test_stop();
    int cyc;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({t1, t2, t3, running} !== {phase_bits(k % 3), 1'b1}) begin
        errors++;
        $display("[TB] FAIL stop_phase k=%0d got=%b exp=%b", k, {t1, t2, t3, running}, {phase_bits(k % 3), 1'b1});
      end
      if (k % 3 == 0) begin
        pop_expected();
        checks++;
        if ({w1, w2, w3} !== got) begin
          errors++;
          $display("[TB] FAIL stop_beat k=%0d got=%b exp=%b", k, {w1, w2, w3}, got);
        end
      end
      if (k == 3) qd = 1'b1;
      if (k % 3 == 2) begin
        short = 1'b0;
        long  = 1'b0;
        stop  = (k == 5);
        exp_cur = next_w(exp_cur, short, long);
        exp_q.push_back(exp_cur);
      end
    end
    tick();
    stop = 1'b0;
    pop_expected();
    checks++;
    if ({w1, w2, w3, t1, t2, t3, running} !== {got, 4'b0000}) begin
      errors++;
      $display("[TB] FAIL stop_halt got=%b exp=%b", {w1, w2, w3, t1, t2, t3, running}, {got, 4'b0000});
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 3) qd = 1'b0;
      tick();
      checks++;
      if ({w1, w2, w3, t1, t2, t3, running} !== 7'b1000000) begin
        errors++;
        $display("[TB] FAIL stop_hold i=%0d got=%b exp=%b", i, {w1, w2, w3, t1, t2, t3, running}, 7'b1000000);
      end
    end
    exp_q.push_back(exp_cur);
    wait_t1(cyc, ok);
    checks++;
    if (!ok || cyc != START_LAT) begin
      errors++;
      $display("[TB] FAIL resume_latency got=%0d exp=%0d ok=%0b", cyc, START_LAT, ok);
    end
    pop_expected();
    checks++;
    if ({w1, w2, w3, t1, t2, t3, running} !== {got, 4'b1001}) begin
      errors++;
      $display("[TB] FAIL resume_state got=%b exp=%b", {w1, w2, w3, t1, t2, t3, running}, {got, 4'b1001});
    end
  endtask

  task automatic test_reset_mid_beat();
    short = 1'b0; long = 1'b0; stop = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      checks++;
      if ({t1, t2, t3, running} !== {phase_bits(k % 3), 1'b1}) begin
        errors++;
        $display("[TB] FAIL mid_phase k=%0d got=%b exp=%b", k, {t1, t2, t3, running}, {phase_bits(k % 3), 1'b1});
      end
      if (k % 3 == 0) begin
        pop_expected();
        checks++;
        if ({w1, w2, w3} !== got) begin
          errors++;
          $display("[TB] FAIL mid_beat k=%0d got=%b exp=%b", k, {w1, w2, w3}, got);
        end
      end
      if (k % 3 == 2) begin
        long = (k == 5);
        exp_cur = next_w(exp_cur, short, long);
        exp_q.push_back(exp_cur);
      end
    end
    #2 clr = 1'b0;
    #1;
    checks++;
    if ({w1, w2, w3, t1, t2, t3, running} !== 7'b1000000) begin
      errors++;
      $display("[TB] FAIL reset_mid_w3 got=%b exp=%b", {w1, w2, w3, t1, t2, t3, running}, 7'b1000000);
    end
    exp_q.delete();
    exp_cur = 3'b100;
    long = 1'b0;
    tick();
    tick();
    clr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({w1, w2, w3, t1, t2, t3, running} !== 7'b1000000) begin
        errors++;
        $display("[TB] FAIL reset_release i=%0d got=%b exp=%b", i, {w1, w2, w3, t1, t2, t3, running}, 7'b1000000);
      end
    end
  endtask

`ifdef SINGLE_STEP_EN
  task automatic test_single_step();
    int cyc;
    bit ok;
    dp = 1'b1; short = 1'b0; long = 1'b0; stop = 1'b0;
    for (int p = 0; p < 4; p++) begin
      exp_q.push_back(exp_cur);
      wait_t1(cyc, ok);
      pop_expected();
      checks++;
      if (!ok || {w1, w2, w3} !== got) begin
        errors++;
        $display("[TB] FAIL step_beat p=%0d got=%b exp=%b ok=%0b", p, {w1, w2, w3}, got, ok);
      end
      tick();
      tick();
      exp_cur = next_w(exp_cur, short, long);
      exp_q.push_back(exp_cur);
      tick();
      pop_expected();
      checks++;
      if ({w1, w2, w3, t1, t2, t3, running} !== {got, 4'b0000}) begin
        errors++;
        $display("[TB] FAIL step_halt p=%0d got=%b exp=%b", p, {w1, w2, w3, t1, t2, t3, running}, {got, 4'b0000});
      end
      tick();
      tick();
    end
    dp = 1'b0;
  endtask
`endif

  initial begin
    $display("[TB] beat_timing_gen bench start");
    test_reset();
    test_short_hold();
    test_long_sequence();
    test_stop();
    test_reset_mid_beat();
`ifdef SINGLE_STEP_EN
    test_single_step();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
